// File: rtl/right_shift_ctrl.sv
// -----------------------------------------------------------------------------
// right_shift_ctrl
//
// Sequencing controller for an external right_shift_reg. It accepts one
// parallel word at a time over a valid/ready handshake and loads it into the
// shift register. It then issues shift enables paced every DIV cycles, so the
// word appears LSB-first on ser_bit. A one-cycle done pulse closes the frame.
// This block drives every control input of the shift register.
//
// Parameters:
//   DW  - word width; must match the shift register's DW
//   DIV - clock cycles each serial bit is held (>= 1)
//
// Ports:
//   clk        in   rising-edge clock, shared with the shift register
//   async_rst  in   asynchronous active-high reset
//   in_valid   in   producer offers in_data / in_fill
//   in_data    in   parallel word to serialize
//   in_fill    in   bit shifted in at the MSB for this word
//   in_ready   out  controller can accept a word this cycle
//   abort      in   synchronous frame abort
//   sr_rst     out  shift register sync_rst
//   sr_load    out  shift register load
//   sr_en      out  shift register en
//   sr_data    out  shift register data
//   sr_data_h  out  shift register data_h
//   sr_q       in   shift register q
//   ser_bit    out  current serial bit (sr_q[0] while ser_valid)
//   ser_valid  out  ser_bit is a valid frame bit
//   busy       out  frame in progress
//   done       out  one-cycle pulse at frame end
// -----------------------------------------------------------------------------
module right_shift_ctrl #(
    parameter int DW  = 4,
    parameter int DIV = 1
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_fill,
    output logic          in_ready,
    input  logic          abort,
    output logic          sr_rst,
    output logic          sr_load,
    output logic          sr_en,
    output logic [DW-1:0] sr_data,
    output logic          sr_data_h,
    input  logic [DW-1:0] sr_q,
    output logic          ser_bit,
    output logic          ser_valid,
    output logic          busy,
    output logic          done
);

    // Counter widths: keep at least one bit so DIV=1 / DW=1 stay legal.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]     hold_word_q, hold_word_d;
    logic              hold_fill_q, hold_fill_d;
    logic              sr_rst_q, sr_rst_d;

    logic div_last;
    logic bit_last;
    logic abort_hit;

    assign div_last  = (div_cnt_q == DIV_LAST);
    assign bit_last  = (bit_cnt_q == BIT_LAST);
    // Abort only acts on a frame in flight; in IDLE it merely blocks acceptance.
    assign abort_hit = abort && (state_q != IDLE);

    // Decoded outputs, purely from registered state and counters.
    assign in_ready  = (state_q == IDLE) && !abort && !sr_rst_q;
    assign sr_rst    = sr_rst_q;
    assign sr_load   = (state_q == LOAD);
    assign sr_en     = (state_q == SHIFT) && div_last;
    assign sr_data   = hold_word_q;
    assign sr_data_h = hold_fill_q;
    assign ser_valid = (state_q == SHIFT);
    assign ser_bit   = ser_valid ? sr_q[0] : 1'b0;
    assign done      = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; without this the tool would infer latches.
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        hold_word_d = hold_word_q;
        hold_fill_d = hold_fill_q;
        sr_rst_d    = 1'b0;

        if (abort_hit) begin
            // Abort wins over every other transition, including SHIFT->DONE.
            state_d   = IDLE;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            sr_rst_d  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        hold_word_d = in_data;
                        hold_fill_d = in_fill;
                        state_d     = LOAD;
                    end
                end
                LOAD: begin
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt_d = '0;
                        if (bit_last) begin
                            // Final shift is still enabled (sr_en decode), so
                            // the register ends up filled with hold_fill.
                            bit_cnt_d = '0;
                            state_d   = DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // sr_rst_q resets to 1 so the shift register sees a sync clear on the
    // first edge after reset release.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            hold_word_q <= '0;
            hold_fill_q <= 1'b0;
            sr_rst_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_word_q <= hold_word_d;
            hold_fill_q <= hold_fill_d;
            sr_rst_q    <= sr_rst_d;
        end
    end

endmodule

// File: tb/tb_right_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_right_shift_ctrl
//
// Two controllers (DIV=1 and DIV=3), each driving a behavioural model of
// right_shift_reg. Directed words are issued together with hand-written
// expected serial streams pushed into per-instance queues. A monitor process
// pops and compares on every ser_valid cycle. Directed checks cover reset,
// end-of-frame register contents, handshake spacing, abort and async reset.
// -----------------------------------------------------------------------------
module tb_right_shift_ctrl;

    logic clk       = 1'b0;
    logic async_rst = 1'b1;

    int checks = 0;
    int errors = 0;

    // DIV=1 instance signals
    logic       v1 = 1'b0, f1 = 1'b0, a1 = 1'b0;
    logic [3:0] d1 = 4'h0;
    logic       rdy1, rst1, load1, en1, data_h1, ser1, sv1, busy1, done1;
    logic [3:0] data1, q1;

    // DIV=3 instance signals
    logic       v3 = 1'b0, f3 = 1'b0, a3 = 1'b0;
    logic [3:0] d3 = 4'h0;
    logic       rdy3, rst3, load3, en3, data_h3, ser3, sv3, busy3, done3;
    logic [3:0] data3, q3;

    bit exp1[$];
    bit exp3[$];
    int done_cnt1 = 0, done_cnt3 = 0, load_cnt1 = 0;
    int sidx3 = 0;

    always #5 clk = ~clk;

    right_shift_ctrl #(.DW(4), .DIV(1)) u_div1 (
        .clk(clk), .async_rst(async_rst),
        .in_valid(v1), .in_data(d1), .in_fill(f1), .in_ready(rdy1),
        .abort(a1),
        .sr_rst(rst1), .sr_load(load1), .sr_en(en1),
        .sr_data(data1), .sr_data_h(data_h1), .sr_q(q1),
        .ser_bit(ser1), .ser_valid(sv1), .busy(busy1), .done(done1)
    );

    right_shift_ctrl #(.DW(4), .DIV(3)) u_div3 (
        .clk(clk), .async_rst(async_rst),
        .in_valid(v3), .in_data(d3), .in_fill(f3), .in_ready(rdy3),
        .abort(a3),
        .sr_rst(rst3), .sr_load(load3), .sr_en(en3),
        .sr_data(data3), .sr_data_h(data_h3), .sr_q(q3),
        .ser_bit(ser3), .ser_valid(sv3), .busy(busy3), .done(done3)
    );

    // Behavioural right_shift_reg models: sync_rst > load > en.
    always @(posedge clk) begin
        if (rst1)      q1 <= 4'h0;
        else if (load1) q1 <= data1;
        else if (en1)   q1 <= {data_h1, q1[3:1]};
    end

    always @(posedge clk) begin
        if (rst3)      q3 <= 4'h0;
        else if (load3) q3 <= data3;
        else if (en3)   q3 <= {data_h3, q3[3:1]};
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Push a hand-written expected serial stream, first character first.
    task automatic push_seq(input int which, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (which == 1) exp1.push_back(s[i] == "1");
            else            exp3.push_back(s[i] == "1");
        end
    endtask

    // Scoreboard monitor: compares every presented serial bit.
    initial begin
        bit b;
        forever begin
            @(negedge clk);
            if (!async_rst) begin
                if (done1) done_cnt1++;
                if (done3) done_cnt3++;
                if (load1) load_cnt1++;
                if (sv1) begin
                    if (exp1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ser_bit_div1: unexpected bit %0b at %0t", ser1, $time);
                    end else begin
                        b = exp1.pop_front();
                        check("ser_bit_div1", {31'd0, ser1}, {31'd0, b});
                    end
                end
                if (sv3) begin
                    if (exp3.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ser_bit_div3: unexpected bit %0b at %0t", ser3, $time);
                    end else begin
                        b = exp3.pop_front();
                        check("ser_bit_div3", {31'd0, ser3}, {31'd0, b});
                    end
                    // Enable only on the last of each group of 3 SHIFT cycles.
                    check("sr_en_div3", {31'd0, en3}, {31'd0, (sidx3 % 3) == 2});
                    sidx3++;
                end else begin
                    sidx3 = 0;
                end
            end
        end
    end

    task automatic send1(input logic [3:0] w, input logic f, output time t_acc);
        int n = 0;
        d1 = w; f1 = f; v1 = 1'b1;
        while (!rdy1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("accept_div1");
        @(posedge clk);
        t_acc = $time;
        #1 v1 = 1'b0;
    endtask

    task automatic send3(input logic [3:0] w, input logic f);
        int n = 0;
        d3 = w; f3 = f; v3 = 1'b1;
        while (!rdy3 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("accept_div3");
        @(posedge clk);
        #1 v3 = 1'b0;
    endtask

    task automatic wait_idle1();
        int n = 0;
        @(negedge clk);
        while (busy1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("idle_div1");
    endtask

    task automatic wait_idle3();
        int n = 0;
        @(negedge clk);
        while (busy3 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("idle_div3");
    endtask

    // Expects async_rst already asserted; holds 3 cycles then releases.
    task automatic reset_seq();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sr_rst", {31'd0, rst1}, 32'd1);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_in_ready", {31'd0, rdy1}, 32'd0);
        async_rst = 1'b0;
        #1;
        check("rel_sr_rst_held", {31'd0, rst1}, 32'd1);
        check("rel_in_ready_low", {31'd0, rdy1}, 32'd0);
        @(negedge clk);
        check("rel_sr_rst_clear", {31'd0, rst1}, 32'd0);
        check("rel_in_ready", {31'd0, rdy1}, 32'd1);
        check("rel_sr_q_div1", {28'd0, q1}, 32'd0);
        check("rel_sr_q_div3", {28'd0, q3}, 32'd0);
    endtask

    initial begin
        time t1, t2;

        // 1. Reset release
        reset_seq();

        // 2. DIV=1, 4'b1011, fill 0
        push_seq(1, "1101");
        send1(4'b1011, 1'b0, t1);
        wait_idle1();
        check("t2_load_cycles", load_cnt1, 32'd1);
        check("t2_done_cnt", done_cnt1, 32'd1);
        check("t2_sr_q", {28'd0, q1}, 32'h0);

        // 3. DIV=3, 4'b0010, fill 1
        push_seq(3, "000111000000");
        send3(4'b0010, 1'b1);
        wait_idle3();
        check("t3_done_cnt", done_cnt3, 32'd1);
        check("t3_sr_q", {28'd0, q3}, 32'hF);

        // 4. Back-to-back 4'hA then 4'h5 with in_valid held
        push_seq(1, "0101");
        push_seq(1, "1010");
        send1(4'hA, 1'b0, t1);
        send1(4'h5, 1'b0, t2);
        wait_idle1();
        check("t4_accept_spacing", 32'((t2 - t1) / 10), 32'd7);
        check("t4_done_cnt", done_cnt1, 32'd3);

        // 5. Abort at 2nd SHIFT cycle of 4'hF
        push_seq(1, "11");
        send1(4'hF, 1'b0, t1);
        @(posedge clk);              // LOAD -> SHIFT0
        @(posedge clk);              // SHIFT0 -> SHIFT1
        #1 a1 = 1'b1;
        @(negedge clk);
        check("t5_busy_in_shift", {31'd0, busy1}, 32'd1);
        @(posedge clk);
        #1 a1 = 1'b0;
        @(negedge clk);
        check("t5_idle_after_abort", {31'd0, busy1}, 32'd0);
        check("t5_sr_rst_pulse", {31'd0, rst1}, 32'd1);
        check("t5_no_done", {31'd0, done1}, 32'd0);
        @(negedge clk);
        check("t5_sr_rst_one_cycle", {31'd0, rst1}, 32'd0);
        check("t5_sr_q_cleared", {28'd0, q1}, 32'h0);
        check("t5_done_cnt_after_abort", done_cnt1, 32'd3);
        push_seq(1, "0110");
        send1(4'b0110, 1'b1, t1);
        wait_idle1();
        check("t5_next_sr_q", {28'd0, q1}, 32'hF);
        check("t5_done_cnt_next", done_cnt1, 32'd4);

        // 6. Async reset mid-SHIFT, between edges
        push_seq(1, "10");
        send1(4'b1001, 1'b0, t1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 async_rst = 1'b1;
        #1;
        check("t6_sr_rst", {31'd0, rst1}, 32'd1);
        check("t6_busy", {31'd0, busy1}, 32'd0);
        check("t6_ser_valid", {31'd0, sv1}, 32'd0);
        check("t6_sr_en", {31'd0, en1}, 32'd0);
        check("t6_sr_load", {31'd0, load1}, 32'd0);
        check("t6_sr_data", {28'd0, data1}, 32'd0);
        check("t6_done", {31'd0, done1}, 32'd0);
        reset_seq();
        check("t6_done_cnt", done_cnt1, 32'd4);

        check("exp1_drained", exp1.size(), 32'd0);
        check("exp3_drained", exp3.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
